// File: rtl/tdm_demux_1x8.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux_1x8
//  Purpose  : Time-division 1-to-8 demultiplexer. Serial beats from a scanned
//             8:1 mux are steered into shadow slots by an internal channel
//             counter. A complete frame is published on a registered 8-bit
//             bus with a one-cycle strobe. A frame-sync input aligns the
//             counter to channel 0, and sync faults are flagged.
//  Ports    :
//    clk          in   1  rising-edge clock
//    rst          in   1  asynchronous active-high reset
//    din          in   1  serial data beat
//    din_valid    in   1  din is sampled on this edge when high
//    sync         in   1  marks the current valid beat as channel 0
//    ch_out       out  8  last complete frame, ch_out[k] = beat at sel=k
//    frame_valid  out  1  one-cycle pulse when ch_out updates
//    sel          out  3  channel index of the next valid beat
//    locked       out  1  high while in RUN
//    sync_err     out  1  one-cycle pulse on a sync fault
//  Params   :
//    SYNC_EACH_FRAME  0: sync needed only to acquire lock
//                     1: sync needed on every channel-0 beat
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux_1x8 #(
  parameter bit SYNC_EACH_FRAME = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [7:0] ch_out,
  output logic       frame_valid,
  output logic [2:0] sel,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state;
  logic [7:0] shadow;

  // Beat classification for the current cycle.
  logic frame_start;   // sync beat that (re)anchors the counter at channel 0
  logic missing_sync;  // channel-0 beat without sync while sync is mandatory
  logic data_write;    // ordinary beat written at the current slot

  always_comb begin
    frame_start  = 1'b0;
    missing_sync = 1'b0;
    data_write   = 1'b0;
    if (din_valid) begin
      if (state == ST_IDLE) begin
        // Beats without sync are dropped until lock is acquired.
        frame_start = sync;
      end else if (sync && (sel != 3'd0)) begin
        // Early sync: the partial frame is abandoned.
        frame_start = 1'b1;
      end else if (!sync && (sel == 3'd0) && SYNC_EACH_FRAME) begin
        missing_sync = 1'b1;
      end else begin
        // Includes a sync at sel=0 and, with SYNC_EACH_FRAME=0, an
        // unsynced channel-0 beat; both land in slot 0 like any other.
        data_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shadow      <= 8'h00;
      sel         <= 3'd0;
      ch_out      <= 8'h00;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;

      if (frame_start) begin
        // A sync seen while already running at sel!=0 is a fault; the same
        // beat still becomes channel 0 of the new frame.
        sync_err  <= (state == ST_RUN);
        shadow[0] <= din;
        sel       <= 3'd1;
        state     <= ST_RUN;
      end else if (missing_sync) begin
        sync_err <= 1'b1;
        state    <= ST_IDLE;
      end else if (data_write) begin
        shadow[sel] <= din;
        sel         <= sel + 3'd1;
        if (sel == 3'd7) begin
          // The channel-7 beat is taken straight from din so the frame is
          // published on the same edge that samples it.
          ch_out      <= {din, shadow[6:0]};
          frame_valid <= 1'b1;
        end
      end
    end
  end

  assign locked = (state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1x8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux_1x8
//  Purpose  : Self-checking bench for tdm_demux_1x8. Two instances share one
//             stimulus stream: one with SYNC_EACH_FRAME=0, one with =1. A
//             frame-level reference model predicts publishes and sync faults;
//             expected frames are queued and a negedge monitor pops them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux_1x8;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic [7:0] ch0, ch1;
  logic       fv0, fv1;
  logic [2:0] sel0, sel1;
  logic       lk0, lk1;
  logic       err0, err1;

  tdm_demux_1x8 #(.SYNC_EACH_FRAME(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .ch_out(ch0), .frame_valid(fv0), .sel(sel0), .locked(lk0), .sync_err(err0)
  );

  tdm_demux_1x8 #(.SYNC_EACH_FRAME(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .ch_out(ch1), .frame_valid(fv1), .sel(sel1), .locked(lk1), .sync_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model (frame level) ----------------
  // Per instance: lock flag, number of bits collected in the current frame,
  // the collected bits, and the last published frame.
  bit         m_lock [2];
  int         m_cnt  [2];
  logic [7:0] m_bits [2];
  logic [7:0] m_pub  [2];
  bit         m_fv   [2];
  bit         m_err  [2];

  logic [7:0] qf0[$], qf1[$];   // expected published frames
  int         qe0[$], qe1[$];   // expected sync faults
  int         beat_no = 0;

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lock[m] = 0; m_cnt[m] = 0; m_bits[m] = 8'h00; m_pub[m] = 8'h00;
      m_fv[m] = 0; m_err[m] = 0;
    end
    qf0.delete(); qf1.delete(); qe0.delete(); qe1.delete();
  endfunction

  function automatic void model_beat(int m, bit v, bit d, bit s);
    bit strict;
    strict  = (m == 1);
    m_fv[m]  = 0;
    m_err[m] = 0;
    if (!v) return;
    if (!m_lock[m]) begin
      if (s) begin
        m_lock[m] = 1; m_bits[m][0] = d; m_cnt[m] = 1;
      end
    end else if (s) begin
      m_err[m] = (m_cnt[m] != 0);
      m_bits[m][0] = d; m_cnt[m] = 1;
    end else if (m_cnt[m] == 0 && strict) begin
      m_err[m] = 1; m_lock[m] = 0;
    end else begin
      m_bits[m][m_cnt[m]] = d;
      m_cnt[m] = m_cnt[m] + 1;
      if (m_cnt[m] == 8) begin
        m_pub[m] = m_bits[m]; m_fv[m] = 1; m_cnt[m] = 0;
      end
    end
    if (m_fv[m])  begin if (m == 0) qf0.push_back(m_pub[m]); else qf1.push_back(m_pub[m]); end
    if (m_err[m]) begin if (m == 0) qe0.push_back(beat_no); else qe1.push_back(beat_no); end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (fv0) begin
        n_checks++;
        if (qf0.size() == 0) begin n_fail++; $display("FAIL pub0: got %0h expected none", ch0); end
        else begin logic [7:0] e; e = qf0.pop_front(); if (ch0 !== e) begin n_fail++; $display("FAIL pub0: got %0h expected %0h", ch0, e); end end
      end
      if (fv1) begin
        n_checks++;
        if (qf1.size() == 0) begin n_fail++; $display("FAIL pub1: got %0h expected none", ch1); end
        else begin logic [7:0] e; e = qf1.pop_front(); if (ch1 !== e) begin n_fail++; $display("FAIL pub1: got %0h expected %0h", ch1, e); end end
      end
      if (err0) begin
        n_checks++;
        if (qe0.size() == 0) begin n_fail++; $display("FAIL err0: got 1 expected 0"); end
        else void'(qe0.pop_front());
      end
      if (err1) begin
        n_checks++;
        if (qe1.size() == 0) begin n_fail++; $display("FAIL err1: got 1 expected 0"); end
        else void'(qe1.pop_front());
      end
      if ((fv0 && err0) || (fv1 && err1)) begin
        n_checks++; n_fail++;
        $display("FAIL fv_err_overlap: got 1 expected 0");
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(bit v, bit d, bit s);
    din = d; din_valid = v; sync = s;
    beat_no++;
    model_beat(0, v, d, s);
    model_beat(1, v, d, s);
    @(posedge clk); #1;
    chk("sel0",    sel0, m_cnt[0]);
    chk("sel1",    sel1, m_cnt[1]);
    chk("locked0", lk0,  m_lock[0]);
    chk("locked1", lk1,  m_lock[1]);
    chk("fv0",     fv0,  m_fv[0]);
    chk("fv1",     fv1,  m_fv[1]);
    chk("err0",    err0, m_err[0]);
    chk("err1",    err1, m_err[1]);
    chk("ch_out0", ch0,  m_pub[0]);
    chk("ch_out1", ch1,  m_pub[1]);
    din_valid = 0; sync = 0;
  endtask

  task automatic send_frame(logic [7:0] f, bit with_sync, int gap_max);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, gap_max)) beat(0, 0, 0);
      beat(1, f[k], with_sync && (k == 0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1;
    #2;
    chk("rst_ch0", ch0, 8'h00);  chk("rst_ch1", ch1, 8'h00);
    chk("rst_sel0", sel0, 0);    chk("rst_sel1", sel1, 0);
    chk("rst_lk0", lk0, 0);      chk("rst_lk1", lk1, 0);
    chk("rst_fv0", fv0, 0);      chk("rst_err1", err1, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] fa, fb, src, ex;
  logic [7:0] pre;
  bit         es_d;

  initial begin
    rst = 1; din = 0; din_valid = 0; sync = 0;
    model_reset();
    #2;
    chk("init_ch0", ch0, 8'h00);
    chk("init_lk0", lk0, 0);
    chk("init_sel1", sel1, 0);
    @(negedge clk); rst = 0;

    // Unsynced traffic while idle is ignored.
    send_frame(8'h5A, 0, 0);
    chk("idle_lk0", lk0, 0);

    // Lock and frame: i0..i7 = 1,0,1,1,0,0,1,0
    fa = 8'b0100_1101;
    send_frame(fa, 1, 0);
    chk("frameA_ch0", ch0, 8'h4D);
    chk("frameA_ch1", ch1, 8'h4D);

    // Mid-frame reset at sel=5, then an unsynced frame is ignored.
    for (int k = 0; k < 5; k++) beat(1, fa[k], k == 0);
    chk("pre_rst_sel", sel0, 5);
    do_reset();
    send_frame(8'hC3, 0, 0);
    chk("post_rst_lk", lk0, 0);
    chk("post_rst_ch", ch0, 8'h00);

    // Gapped frame then back-to-back frame 0,1,1,1,1,1,1,1.
    send_frame(fa, 1, 3);
    chk("gapA_ch0", ch0, 8'h4D);
    fb = 8'hFE;
    send_frame(fb, 1, 0);
    chk("b2b_ch0", ch0, 8'hFE);
    chk("b2b_ch1", ch1, 8'hFE);

    // Early sync at sel=4; the sync beat anchors the next frame.
    pre = 8'($urandom);
    for (int k = 0; k < 4; k++) beat(1, pre[k], k == 0);
    es_d = 1'b1;
    beat(1, es_d, 1);
    chk("early_sel", sel0, 1);
    src = 8'($urandom);
    for (int k = 1; k < 8; k++) beat(1, src[k], 0);
    ex = {src[7:1], es_d};
    chk("early_ch0", ch0, ex);
    chk("early_ch1", ch1, ex);

    // Missing sync on channel 0: strict instance drops lock, keeps frame.
    send_frame(fa, 1, 0);
    send_frame(fb, 0, 0);
    chk("miss_ch1_hold", ch1, 8'h4D);
    chk("miss_lk1", lk1, 0);
    chk("miss_ch0", ch0, 8'hFE);
    send_frame(8'h96, 1, 0);
    chk("relock_ch1", ch1, 8'h96);

    // Mux round trip: din is the 8:1 mux output for sel 0..7.
    for (int n = 0; n < 20; n++) begin
      src = 8'($urandom);
      send_frame(src, 1, (n % 3 == 0) ? 2 : 0);
      chk("rt_ch0", ch0, src);
      chk("rt_ch1", ch1, src);
    end

    // Random traffic, including stray syncs and gaps.
    for (int n = 0; n < 400; n++)
      beat($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0);

    beat(0, 0, 0);
    @(negedge clk); #1;
    chk("left_qf0", qf0.size(), 0);
    chk("left_qf1", qf1.size(), 0);
    chk("left_qe0", qe0.size(), 0);
    chk("left_qe1", qe1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
